// File: rtl/pipeline_hazard_tracker.sv
// rtl/pipeline_hazard_tracker.sv - EXE/MEM/WB destination tracking and load-use stall detection
// Optional retired-instruction counter enabled by HAZARD_RETIRE_CNT_EN.
module pipeline_hazard_tracker #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             flush,
  input  logic             freeze,
  output logic [RA_W-1:0]  erd,
  output logic [RA_W-1:0]  mrd,
  output logic [RA_W-1:0]  wrd,
  output logic             ewreg,
  output logic             mwreg,
  output logic             wwreg,
  output logic             em2reg,
  output logic             mm2reg,
  output logic             wm2reg,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] retired
);

  logic            e_valid;
  logic            m_valid;
  logic            ins_wreg;
  logic [RA_W-1:0] ins_rd;
  logic            bubble_e;

  // x0 is never tracked as a write, so rd reads 0 whenever wreg is 0.
  assign ins_wreg = id_wreg && (id_rd != '0);
  assign ins_rd   = ins_wreg ? id_rd : '0;

  assign load_use_stall = id_valid && e_valid && em2reg && ewreg &&
                          ((id_use_rs1 && (id_rs1 == erd)) ||
                           (id_use_rs2 && (id_rs2 == erd)));

  assign bubble_e = !id_valid || flush || load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      erd     <= '0;
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      m_valid <= 1'b0;
      mrd     <= '0;
      mwreg   <= 1'b0;
      mm2reg  <= 1'b0;
      wrd     <= '0;
      wwreg   <= 1'b0;
      wm2reg  <= 1'b0;
    end else if (!freeze) begin
      wrd     <= mrd;
      wwreg   <= mwreg;
      wm2reg  <= mm2reg;
      m_valid <= e_valid;
      mrd     <= erd;
      mwreg   <= ewreg;
      mm2reg  <= em2reg;
      if (bubble_e) begin
        e_valid <= 1'b0;
        erd     <= '0;
        ewreg   <= 1'b0;
        em2reg  <= 1'b0;
      end else begin
        e_valid <= 1'b1;
        erd     <= ins_rd;
        ewreg   <= ins_wreg;
        em2reg  <= id_m2reg && ins_wreg;
      end
    end
  end

`ifdef HAZARD_RETIRE_CNT_EN
  logic             w_valid;
  logic [CNT_W-1:0] retired_q;

  // Counts every instruction leaving WB, writing or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid   <= 1'b0;
      retired_q <= '0;
    end else if (!freeze) begin
      w_valid <= m_valid;
      if (w_valid) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`else
  logic unused_m_valid;
  assign unused_m_valid = m_valid;
  assign retired        = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// tb/tb_pipeline_hazard_tracker.sv - directed self-checking bench for pipeline_hazard_tracker
module tb_pipeline_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_wreg, id_m2reg, id_use_rs1, id_use_rs2, flush, freeze;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic [4:0] erd, mrd, wrd;
  logic       ewreg, mwreg, wwreg, em2reg, mm2reg, wm2reg, load_use_stall;
  logic [3:0] retired;
  int         n_assert = 0;
  int         n_fail   = 0;

  pipeline_hazard_tracker #(.RA_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .flush(flush), .freeze(freeze), .erd(erd), .mrd(mrd),
    .wrd(wrd), .ewreg(ewreg), .mwreg(mwreg), .wwreg(wwreg), .em2reg(em2reg),
    .mm2reg(mm2reg), .wm2reg(wm2reg), .load_use_stall(load_use_stall), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rd = 0; id_wreg = 0; id_m2reg = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic ins(input logic [4:0] rd, input logic w, input logic ld,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2);
    id_valid = 1; id_rd = rd; id_wreg = w; id_m2reg = ld;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_erd"}, 32'(erd), 0);
    chk({tag, "_mrd"}, 32'(mrd), 0);
    chk({tag, "_wrd"}, 32'(wrd), 0);
    chk({tag, "_flags"}, 32'({ewreg, mwreg, wwreg, em2reg, mm2reg, wm2reg}), 0);
    chk({tag, "_stall"}, 32'(load_use_stall), 0);
    chk({tag, "_retired"}, 32'(retired), 0);
  endtask

  initial begin
    rst = 1; flush = 0; freeze = 0;
    idle();
    #12;
    chk_zero("reset");
    rst = 0;

    // shift rd=5 through E, M, W
    ins(5, 1, 0, 0, 0, 0, 0);
    step(); idle();
    chk("shift_erd", 32'(erd), 5);
    chk("shift_ewreg", 32'(ewreg), 1);
    step();
    chk("shift_mrd", 32'(mrd), 5);
    chk("shift_erd_bub", 32'(erd), 0);
    step();
    chk("shift_wrd", 32'(wrd), 5);
    chk("shift_wwreg", 32'(wwreg), 1);
    step();
    chk("shift_wrd_bub", 32'(wrd), 0);
    chk("shift_wwreg_bub", 32'(wwreg), 0);

    // write to x0 is not tracked
    ins(0, 1, 1, 0, 0, 0, 0);
    step(); idle();
    chk("x0_erd", 32'(erd), 0);
    chk("x0_ewreg", 32'(ewreg), 0);
    chk("x0_em2reg", 32'(em2reg), 0);

    // load-use hazard on rs2
    ins(7, 1, 1, 0, 0, 0, 0);
    step();
    chk("lu_erd", 32'(erd), 7);
    chk("lu_em2reg", 32'(em2reg), 1);
    ins(3, 1, 0, 0, 7, 0, 1);
    #1;
    chk("lu_stall", 32'(load_use_stall), 1);
    step();
    chk("lu_bubble_ewreg", 32'(ewreg), 0);
    chk("lu_bubble_erd", 32'(erd), 0);
    chk("lu_mrd", 32'(mrd), 7);
    chk("lu_mm2reg", 32'(mm2reg), 1);
    chk("lu_stall_clear", 32'(load_use_stall), 0);
    step(); idle();
    chk("lu_retry_erd", 32'(erd), 3);

    // same pair with rs2 unused: no stall
    ins(7, 1, 1, 0, 0, 0, 0);
    step();
    ins(3, 1, 0, 0, 7, 0, 0);
    #1;
    chk("nolu_stall", 32'(load_use_stall), 0);
    step(); idle();
    chk("nolu_erd", 32'(erd), 3);
    chk("nolu_mrd", 32'(mrd), 7);

    // hazard through rs1
    ins(8, 1, 1, 0, 0, 0, 0);
    step();
    ins(4, 1, 0, 8, 0, 1, 0);
    #1;
    chk("lu_rs1_stall", 32'(load_use_stall), 1);
    step(); idle();

    // flush turns valid ID into a bubble
    ins(9, 1, 0, 0, 0, 0, 0);
    flush = 1;
    step();
    flush = 0; idle();
    chk("flush_erd", 32'(erd), 0);
    chk("flush_ewreg", 32'(ewreg), 0);

    // freeze holds everything and ignores flush/ID
    ins(1, 1, 0, 0, 0, 0, 0); step();
    ins(2, 1, 0, 0, 0, 0, 0); step();
    ins(3, 1, 0, 0, 0, 0, 0); step();
    freeze = 1; flush = 1;
    ins(4, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_erd", 32'(erd), 3);
      chk("frz_mrd", 32'(mrd), 2);
      chk("frz_wrd", 32'(wrd), 1);
    end
    freeze = 0; flush = 0; idle();

    // asynchronous reset mid-stream
    ins(10, 1, 0, 0, 0, 0, 0); step();
    ins(11, 1, 0, 0, 0, 0, 0); step();
    ins(12, 1, 0, 0, 0, 0, 0); step();
    idle();
    chk("pre_rst_erd", 32'(erd), 12);
    chk("pre_rst_wrd", 32'(wrd), 10);
    #2 rst = 1;
    #1;
    chk_zero("midrst");
    rst = 0;
    step();

`ifdef HAZARD_RETIRE_CNT_EN
    for (int i = 1; i <= 10; i++) begin
      ins(5'(i), (i % 3) != 0, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    step(); step();
    chk("cnt_9", 32'(retired), 9);
    step();
    chk("cnt_10", 32'(retired), 10);
    for (int i = 0; i < 6; i++) begin
      ins(5'(i + 1), 1, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    step(); step();
    chk("cnt_15", 32'(retired), 15);
    step();
    chk("cnt_wrap", 32'(retired), 0);
`else
    for (int i = 0; i < 5; i++) begin
      ins(5'(i + 1), 1, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    step(); step(); step();
    chk("cnt_tied", 32'(retired), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
